// File: rtl/pipe_pkg.sv
// Shared slot state type, default geometry and width helpers for the pipe array.
package pipe_pkg;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_ACTIVE = 1'b1
  } slot_state_t;

  localparam int unsigned DEF_NUM_PIPES  = 3;
  localparam int unsigned DEF_WIDTH      = 40;
  localparam int unsigned DEF_HEIGHT     = 30;
  localparam int unsigned DEF_PIXEL_SIZE = 16;
  localparam int unsigned DEF_PIPE_WIDTH = 5;
  localparam int unsigned DEF_GAP_SIZE   = 10;
  localparam int unsigned DEF_SCORE_W    = 8;
  localparam int unsigned DEF_XMAX       = 800;
  localparam int unsigned DEF_YMAX       = 525;

  localparam int unsigned DEF_XW = $clog2(DEF_XMAX);
  localparam int unsigned DEF_YW = $clog2(DEF_YMAX);
  localparam int unsigned DEF_GW = $clog2(DEF_HEIGHT);

  // Tile offset width: must hold 0..WIDTH+PIPE_WIDTH.
  function automatic int unsigned off_width(input int unsigned width,
                                            input int unsigned pipe_width);
    return $clog2(width + pipe_width + 1);
  endfunction

  // Pixel compare width: one bit of headroom over the raster counter.
  function automatic int unsigned pix_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/pipe_array_ctrl_if.sv
// Raster/control inputs and pipe status outputs of the pipe array controller.
interface pipe_array_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_PIPES = DEF_NUM_PIPES,
  parameter int unsigned XW        = DEF_XW,
  parameter int unsigned YW        = DEF_YW,
  parameter int unsigned GW        = DEF_GW,
  parameter int unsigned SCORE_W   = DEF_SCORE_W
);

  logic [XW-1:0]        i_X_Count;
  logic [YW-1:0]        i_Y_Count;
  logic                 i_Enable;
  logic                 i_Clear;
  logic [GW-1:0]        i_Gap_Y;
  logic                 o_Draw_Pipe;
  logic                 o_Gap_Ack;
  logic                 o_Pass_Tick;
  logic [SCORE_W-1:0]   o_Score;
  logic [NUM_PIPES-1:0] o_Active;

  modport master (
    output i_X_Count, i_Y_Count, i_Enable, i_Clear, i_Gap_Y,
    input  o_Draw_Pipe, o_Gap_Ack, o_Pass_Tick, o_Score, o_Active
  );

  modport slave (
    input  i_X_Count, i_Y_Count, i_Enable, i_Clear, i_Gap_Y,
    output o_Draw_Pipe, o_Gap_Ack, o_Pass_Tick, o_Score, o_Active
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipe slot: position/gap state, scroll and spawn update, pass detect and pixel hit test.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned PIXEL_SIZE = DEF_PIXEL_SIZE,
  parameter int unsigned PIPE_WIDTH = DEF_PIPE_WIDTH,
  parameter int unsigned GAP_SIZE   = DEF_GAP_SIZE,
  parameter int unsigned BIRD_X     = 8,
  parameter int unsigned XMAX       = DEF_XMAX,
  parameter int unsigned YMAX       = DEF_YMAX
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset_n,
  input  logic                      clear,
  input  logic                      step,
  input  logic                      load,
  input  logic [$clog2(HEIGHT)-1:0] gap,
  input  logic [$clog2(XMAX)-1:0]   x_count,
  input  logic [$clog2(YMAX)-1:0]   y_count,
  output logic                      active,
  output logic                      pass_c,
  output logic                      hit_c
);

  localparam int unsigned GW   = $clog2(HEIGHT);
  localparam int unsigned OFFW = off_width(WIDTH, PIPE_WIDTH);
  localparam int unsigned PXW  = pix_width(XMAX);
  localparam int unsigned PYW  = pix_width(YMAX);
  localparam logic [OFFW-1:0] OFF_SPAWN = OFFW'(WIDTH + PIPE_WIDTH);

  slot_state_t     state_q, state_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [OFFW-1:0] left_tile, right_tile;
  logic [PXW-1:0]  x_pix, x_lo, x_hi;
  logic [PYW-1:0]  y_pix, y_top, y_bot;

  // Slot state, offset and gap registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= SLOT_IDLE;
      off_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      gap_q   <= gap_d;
    end
  end

  // Next state: scroll left on a step, retire at offset 0, load on spawn.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    gap_d   = gap_q;
    if (clear) begin
      state_d = SLOT_IDLE;
      off_d   = '0;
      gap_d   = '0;
    end else if (step) begin
      case (state_q)
        SLOT_ACTIVE: begin
          off_d = off_q - OFFW'(1);
          if (off_q == OFFW'(1)) state_d = SLOT_IDLE;
        end
        SLOT_IDLE: begin
          if (load) begin
            state_d = SLOT_ACTIVE;
            off_d   = OFF_SPAWN;
            gap_d   = gap;
          end
        end
        default: state_d = SLOT_IDLE;
      endcase
    end
  end

  assign active = (state_q == SLOT_ACTIVE);

  // Right edge lands on the bird column with this step.
  assign pass_c = step && active && (off_q == OFFW'(BIRD_X + 1));

  // Visible tile span: left edge clipped at 0, right edge clipped at the field width.
  assign left_tile  = (off_q >= OFFW'(PIPE_WIDTH)) ? off_q - OFFW'(PIPE_WIDTH) : '0;
  assign right_tile = (off_q > OFFW'(WIDTH)) ? OFFW'(WIDTH) : off_q;

  assign x_pix = PXW'(x_count);
  assign y_pix = PYW'(y_count);
  assign x_lo  = PXW'(left_tile) * PXW'(PIXEL_SIZE);
  assign x_hi  = PXW'(right_tile) * PXW'(PIXEL_SIZE);
  assign y_top = PYW'(gap_q) * PYW'(PIXEL_SIZE);
  assign y_bot = (PYW'(gap_q) + PYW'(GAP_SIZE)) * PYW'(PIXEL_SIZE);

  assign hit_c = active && (x_pix >= x_lo) && (x_pix < x_hi) &&
                 ((y_pix < y_top) || (y_pix >= y_bot));

endmodule

// File: rtl/pipe_array_ctrl.sv
// Pipe array controller: scroll/spawn timing, spawn arbitration, scoring and draw merge.
module pipe_array_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_PIPES     = DEF_NUM_PIPES,
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned HEIGHT        = DEF_HEIGHT,
  parameter int unsigned PIXEL_SIZE    = DEF_PIXEL_SIZE,
  parameter int unsigned PIPE_WIDTH    = DEF_PIPE_WIDTH,
  parameter int unsigned GAP_SIZE      = DEF_GAP_SIZE,
  parameter int unsigned MOVE_SPEED    = 1250000,
  parameter int unsigned SPAWN_SPACING = 15,
  parameter int unsigned BIRD_X        = 8,
  parameter int unsigned SCORE_W       = DEF_SCORE_W,
  parameter int unsigned XMAX          = DEF_XMAX,
  parameter int unsigned YMAX          = DEF_YMAX
) (
  input logic              i_Clk,
  input logic              i_Reset_n,
  pipe_array_ctrl_if.slave bus
);

  localparam int unsigned GW  = $clog2(HEIGHT);
  localparam int unsigned MVW = $clog2(MOVE_SPEED + 1);
  localparam int unsigned SPW = $clog2(SPAWN_SPACING + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(HEIGHT - GAP_SIZE);

  logic [MVW-1:0]       mv_q, mv_d;
  logic [SPW-1:0]       sp_q, sp_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 ack_q, ack_d;
  logic                 pass_q, pass_d;
  logic                 draw_q, draw_d;
  logic                 step_c, spawn_c, found;
  logic [GW-1:0]        gap_clamp_c;
  logic [NUM_PIPES-1:0] active, load_c, pass_c, hit_c;

  assign step_c      = bus.i_Enable && (mv_q == MVW'(MOVE_SPEED - 1));
  assign spawn_c     = step_c && !bus.i_Clear && (sp_q == '0) && !(&active);
  assign gap_clamp_c = (bus.i_Gap_Y > GAP_MAX) ? GAP_MAX : bus.i_Gap_Y;

  // Lowest-index slot that was idle before this step receives the spawn.
  always_comb begin
    load_c = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NUM_PIPES); i++) begin
      if (spawn_c && !active[i] && !found) begin
        load_c[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < int'(NUM_PIPES); gi++) begin : g_slot
    pipe_slot #(
      .WIDTH      (WIDTH),
      .HEIGHT     (HEIGHT),
      .PIXEL_SIZE (PIXEL_SIZE),
      .PIPE_WIDTH (PIPE_WIDTH),
      .GAP_SIZE   (GAP_SIZE),
      .BIRD_X     (BIRD_X),
      .XMAX       (XMAX),
      .YMAX       (YMAX)
    ) u_slot (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .clear     (bus.i_Clear),
      .step      (step_c),
      .load      (load_c[gi]),
      .gap       (gap_clamp_c),
      .x_count   (bus.i_X_Count),
      .y_count   (bus.i_Y_Count),
      .active    (active[gi]),
      .pass_c    (pass_c[gi]),
      .hit_c     (hit_c[gi])
    );
  end

  // Move/spawn counters, score and registered pulse/draw outputs.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      mv_q    <= '0;
      sp_q    <= '0;
      score_q <= '0;
      ack_q   <= 1'b0;
      pass_q  <= 1'b0;
      draw_q  <= 1'b0;
    end else begin
      mv_q    <= mv_d;
      sp_q    <= sp_d;
      score_q <= score_d;
      ack_q   <= ack_d;
      pass_q  <= pass_d;
      draw_q  <= draw_d;
    end
  end

  // Counter sequencing; a busy array holds the spawn counter at 0 until a slot frees.
  always_comb begin
    mv_d    = mv_q;
    sp_d    = sp_q;
    score_d = score_q;
    ack_d   = 1'b0;
    pass_d  = 1'b0;
    draw_d  = |hit_c;
    if (bus.i_Clear) begin
      mv_d    = '0;
      sp_d    = '0;
      score_d = '0;
      draw_d  = 1'b0;
    end else begin
      if (bus.i_Enable) mv_d = step_c ? '0 : mv_q + MVW'(1);
      if (step_c) begin
        if (sp_q != '0) begin
          sp_d = sp_q - SPW'(1);
        end else if (spawn_c) begin
          sp_d  = SPW'(SPAWN_SPACING - 1);
          ack_d = 1'b1;
        end
        pass_d = |pass_c;
        if (pass_d) score_d = score_q + SCORE_W'(1);
      end
    end
  end

  assign bus.o_Draw_Pipe = draw_q;
  assign bus.o_Gap_Ack   = ack_q;
  assign bus.o_Pass_Tick = pass_q;
  assign bus.o_Score     = score_q;
  assign bus.o_Active    = active;

endmodule

// File: tb/tb_pipe_array_ctrl.sv
// Bench for pipe_array_ctrl: two instances (spawn spacing 6 and 3) share one stimulus stream.
module tb_pipe_array_ctrl;

  localparam int NP   = 2;
  localparam int W    = 10;
  localparam int PW   = 2;
  localparam int PS   = 4;
  localparam int MS   = 4;
  localparam int BX   = 3;
  localparam int GS   = 3;
  localparam int H    = 8;
  localparam int SW   = 8;
  localparam int XMAX = 800;
  localparam int YMAX = 525;
  localparam int XW   = $clog2(XMAX);
  localparam int YW   = $clog2(YMAX);
  localparam int GW   = $clog2(H);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [GW-1:0] gap;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always #5 clk = ~clk;

  pipe_array_ctrl_if #(.NUM_PIPES(NP), .XW(XW), .YW(YW), .GW(GW), .SCORE_W(SW)) bus_a ();
  pipe_array_ctrl_if #(.NUM_PIPES(NP), .XW(XW), .YW(YW), .GW(GW), .SCORE_W(SW)) bus_b ();

  assign bus_a.i_X_Count = x;
  assign bus_a.i_Y_Count = y;
  assign bus_a.i_Enable  = en;
  assign bus_a.i_Clear   = clr;
  assign bus_a.i_Gap_Y   = gap;
  assign bus_b.i_X_Count = x;
  assign bus_b.i_Y_Count = y;
  assign bus_b.i_Enable  = en;
  assign bus_b.i_Clear   = clr;
  assign bus_b.i_Gap_Y   = gap;

  pipe_array_ctrl #(
    .NUM_PIPES(NP), .WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS), .PIPE_WIDTH(PW),
    .GAP_SIZE(GS), .MOVE_SPEED(MS), .SPAWN_SPACING(6), .BIRD_X(BX),
    .SCORE_W(SW), .XMAX(XMAX), .YMAX(YMAX)
  ) dut_a (
    .i_Clk(clk), .i_Reset_n(rst_n), .bus(bus_a)
  );

  pipe_array_ctrl #(
    .NUM_PIPES(NP), .WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS), .PIPE_WIDTH(PW),
    .GAP_SIZE(GS), .MOVE_SPEED(MS), .SPAWN_SPACING(3), .BIRD_X(BX),
    .SCORE_W(SW), .XMAX(XMAX), .YMAX(YMAX)
  ) dut_b (
    .i_Clk(clk), .i_Reset_n(rst_n), .bus(bus_b)
  );

  // Reference model: per-instance pipe list, clock counters and expected outputs.
  int m_act [2][NP];
  int m_off [2][NP];
  int m_g   [2][NP];
  int m_mv  [2];
  int m_sp  [2];
  int m_score [2];
  int e_ack [2];
  int e_pass[2];
  int e_draw[2];

  int n_pass  = 0;
  int n_total = 0;
  int ack_a   = 0;
  int ack_b   = 0;

  function automatic int spacing(input int k);
    return (k == 0) ? 6 : 3;
  endfunction

  task automatic model_clear(input int k);
    for (int p = 0; p < NP; p++) begin
      m_act[k][p] = 0;
      m_off[k][p] = 0;
      m_g[k][p]   = 0;
    end
    m_mv[k]    = 0;
    m_sp[k]    = 0;
    m_score[k] = 0;
    e_ack[k]   = 0;
    e_pass[k]  = 0;
    e_draw[k]  = 0;
  endtask

  task automatic model_edge(input int k);
    int hit, xi, yi, lo, hi, step, free_slot;
    int idle_before[NP];
    xi  = int'(x);
    yi  = int'(y);
    hit = 0;
    for (int p = 0; p < NP; p++) begin
      if (m_act[k][p] != 0) begin
        lo = (m_off[k][p] > PW) ? m_off[k][p] - PW : 0;
        hi = (m_off[k][p] < W) ? m_off[k][p] : W;
        if (xi >= lo * PS && xi < hi * PS &&
            (yi < m_g[k][p] * PS || yi >= (m_g[k][p] + GS) * PS)) hit = 1;
      end
    end
    if (clr) begin
      model_clear(k);
      return;
    end
    step = (en && m_mv[k] == MS - 1) ? 1 : 0;
    if (en) m_mv[k] = (m_mv[k] + 1) % MS;
    e_ack[k]  = 0;
    e_pass[k] = 0;
    if (step != 0) begin
      for (int p = 0; p < NP; p++) idle_before[p] = (m_act[k][p] == 0) ? 1 : 0;
      for (int p = 0; p < NP; p++) begin
        if (m_act[k][p] != 0) begin
          m_off[k][p] = m_off[k][p] - 1;
          if (m_off[k][p] == BX) e_pass[k] = 1;
          if (m_off[k][p] == 0) m_act[k][p] = 0;
        end
      end
      if (m_sp[k] == 0) begin
        free_slot = -1;
        for (int p = 0; p < NP; p++)
          if (idle_before[p] != 0 && free_slot < 0) free_slot = p;
        if (free_slot >= 0) begin
          m_act[k][free_slot] = 1;
          m_off[k][free_slot] = W + PW;
          m_g[k][free_slot]   = (int'(gap) < H - GS) ? int'(gap) : H - GS;
          e_ack[k] = 1;
          m_sp[k]  = spacing(k) - 1;
        end
      end else begin
        m_sp[k] = m_sp[k] - 1;
      end
      if (e_pass[k] != 0) m_score[k] = (m_score[k] + 1) % 256;
    end
    e_draw[k] = hit;
  endtask

  function automatic int exp_active(input int k);
    int v;
    v = 0;
    for (int p = 0; p < NP; p++) if (m_act[k][p] != 0) v += (1 << p);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Model advances on the same edges as the DUTs.
  initial begin
    model_clear(0);
    model_clear(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear(0);
        model_clear(1);
      end else begin
        model_edge(0);
        model_edge(1);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("a_draw",   int'(bus_a.o_Draw_Pipe), e_draw[0]);
      check("a_ack",    int'(bus_a.o_Gap_Ack),   e_ack[0]);
      check("a_pass",   int'(bus_a.o_Pass_Tick), e_pass[0]);
      check("a_score",  int'(bus_a.o_Score),     m_score[0]);
      check("a_active", int'(bus_a.o_Active),    exp_active(0));
      check("b_draw",   int'(bus_b.o_Draw_Pipe), e_draw[1]);
      check("b_ack",    int'(bus_b.o_Gap_Ack),   e_ack[1]);
      check("b_pass",   int'(bus_b.o_Pass_Tick), e_pass[1]);
      check("b_score",  int'(bus_b.o_Score),     m_score[1]);
      check("b_active", int'(bus_b.o_Active),    exp_active(1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  task automatic cycles(input int n, input bit sweep);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ack_a += int'(bus_a.o_Gap_Ack);
      ack_b += int'(bus_b.o_Gap_Ack);
      if (sweep) begin
        x = XW'((int'(x) + 3) % 48);
        y = YW'((int'(y) + 5) % 36);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    gap   = GW'(2);
    x     = '0;
    y     = '0;
    #2 rst_n = 1'b0;
    cycles(2, 1'b0);
    rst_n = 1'b1;

    // First spawn lands on the 4th edge after release.
    cycles(3, 1'b0);
    check("lit_ack_edge3", int'(bus_a.o_Gap_Ack), 0);
    cycles(1, 1'b0);
    check("lit_ack_edge4_a", int'(bus_a.o_Gap_Ack), 1);
    check("lit_ack_edge4_b", int'(bus_b.o_Gap_Ack), 1);
    check("lit_active_edge4", int'(bus_a.o_Active), 1);
    check("lit_model_off_spawn", m_off[0][0], 12);
    gap = GW'(7);

    // Slot0 at OFF=10, G=2: pixel hit tests.
    cycles(8, 1'b0);
    check("lit_model_off10", m_off[0][0], 10);
    x = XW'(36); y = YW'(12);
    cycles(1, 1'b0);
    check("lit_draw_in_gap", int'(bus_a.o_Draw_Pipe), 0);
    y = YW'(24);
    cycles(1, 1'b0);
    check("lit_draw_below_gap", int'(bus_a.o_Draw_Pipe), 1);
    x = XW'(40); y = YW'(0);
    cycles(1, 1'b0);
    check("lit_draw_right_edge", int'(bus_a.o_Draw_Pipe), 0);
    x = XW'(32); y = YW'(4);
    cycles(1, 1'b0);
    check("lit_draw_above_gap", int'(bus_a.o_Draw_Pipe), 1);
    check("lit_b_two_active", int'(bus_b.o_Active), 3);

    // Slot0 steps 4->3 on edge 40: one pass.
    cycles(23, 1'b1);
    check("lit_pass_before", int'(bus_a.o_Pass_Tick), 0);
    cycles(1, 1'b1);
    check("lit_pass_a", int'(bus_a.o_Pass_Tick), 1);
    check("lit_score_a", int'(bus_a.o_Score), 1);
    check("lit_pass_b", int'(bus_b.o_Pass_Tick), 1);
    check("lit_model_gap_clamp_a", m_g[0][1], 5);
    check("lit_model_gap_clamp_b", m_g[1][1], 5);

    // Full array defers the spawn; freed slot is not reused on its own tick.
    ack_a = 0;
    ack_b = 0;
    cycles(15, 1'b1);
    check("lit_no_ack_a", ack_a, 0);
    check("lit_no_ack_b", ack_b, 0);
    check("lit_active_a_e55", int'(bus_a.o_Active), 2);
    check("lit_active_b_e55", int'(bus_b.o_Active), 2);
    check("lit_score_b_e55", int'(bus_b.o_Score), 2);
    cycles(1, 1'b1);
    check("lit_deferred_ack_a", int'(bus_a.o_Gap_Ack), 1);
    check("lit_deferred_ack_b", int'(bus_b.o_Gap_Ack), 1);
    check("lit_active_a_e56", int'(bus_a.o_Active), 3);
    check("lit_active_b_e56", int'(bus_b.o_Active), 3);

    // Pause: positions frozen, pipes still drawn.
    en = 1'b0;
    cycles(20, 1'b1);
    check("lit_pause_active_a", int'(bus_a.o_Active), 3);
    check("lit_pause_score_a", int'(bus_a.o_Score), 1);
    check("lit_pause_score_b", int'(bus_b.o_Score), 2);
    check("lit_model_frozen_off", m_off[0][1], 5);
    x = XW'(16); y = YW'(0);
    cycles(1, 1'b0);
    check("lit_pause_draw_hit", int'(bus_a.o_Draw_Pipe), 1);
    y = YW'(24);
    cycles(1, 1'b0);
    check("lit_pause_draw_gap", int'(bus_a.o_Draw_Pipe), 0);

    // Clear overrides an enabled step.
    clr = 1'b1;
    en  = 1'b1;
    cycles(1, 1'b0);
    clr = 1'b0;
    check("lit_clear_active_a", int'(bus_a.o_Active), 0);
    check("lit_clear_score_a", int'(bus_a.o_Score), 0);
    check("lit_clear_active_b", int'(bus_b.o_Active), 0);
    check("lit_clear_score_b", int'(bus_b.o_Score), 0);
    cycles(4, 1'b1);
    check("lit_clear_respawn", int'(bus_a.o_Gap_Ack), 1);
    cycles(60, 1'b1);

    // Mid-frame reset, then first spawn after MOVE_SPEED clocks.
    #3 rst_n = 1'b0;
    cycles(1, 1'b1);
    check("lit_rst_active", int'(bus_a.o_Active), 0);
    check("lit_rst_score", int'(bus_a.o_Score), 0);
    check("lit_rst_draw", int'(bus_a.o_Draw_Pipe), 0);
    cycles(1, 1'b1);
    rst_n = 1'b1;
    cycles(3, 1'b1);
    check("lit_rst_ack_early", int'(bus_a.o_Gap_Ack), 0);
    cycles(1, 1'b1);
    check("lit_rst_ack_a", int'(bus_a.o_Gap_Ack), 1);
    check("lit_rst_ack_b", int'(bus_b.o_Gap_Ack), 1);
    check("lit_rst_active_after", int'(bus_a.o_Active), 1);
    cycles(20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
